pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised program-counter and branch-resolution unit for the ARMv8 core. It replaces the fixed "pc + 4 unless branch" incrementer.
- Each cycle it computes the next PC for sequential flow, B (unconditional), CBZ/CBNZ (zero branch) and B.cond (flag branch).
- It holds the architectural NZCV flags register and implements a HLT/resume state machine.
- It sits between the control unit (branch strobes) and instruction fetch.

Parameters:
- ADDR_W, 64, PC/target width; all arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.
- INST_BYTES, 4, sequential increment in bytes.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instruction  in  32  current instruction word at pc
- stall  in  1  hold all state (pc, flags, FSM) this cycle
- uncond_branch  in  1  control: B
- zero_branch  in  1  control: CBZ/CBNZ; instruction[24]=1 selects CBNZ
- flag_branch  in  1  control: B.cond; condition = instruction[3:0]
- reg_value  in  64  Rt operand for CBZ/CBNZ
- flag_write  in  1  latch flags_in this cycle
- flags_in  in  4  NZCV from ALU, bit3=N, bit2=Z, bit1=C, bit0=V
- resume  in  1  leave HALTED state
- pc  out  ADDR_W  current PC (registered)
- flags  out  4  architectural NZCV (registered)
- halted  out  1  high while in HALTED
- branch_taken  out  1  one-cycle registered pulse after a taken branch updates pc

Behaviour:
- Reset state: pc=RESET_PC, flags=4'b0000, FSM=RUN, halted=0, branch_taken=0. Reset asserted mid-operation overrides everything, including stall.
- FSM states:
  - RUN: normal sequencing.
  - HALTED: pc and flags frozen.
- HLT decode: instruction[31:21]==11'b11010100010 and instruction[4:0]==5'b00000.
  - In RUN with stall=0 and HLT decoded: FSM goes to HALTED and pc holds at the HLT address.
  - HLT decode takes priority over every branch strobe.
- In HALTED with resume=1: FSM returns to RUN and pc <= pc+INST_BYTES, so execution continues past the HLT.
  - stall is ignored in HALTED.
  - resume is ignored in RUN.
- In RUN with stall=1: pc, flags and FSM hold, and branch_taken is 0 next cycle.
- Offsets are sign-extended to ADDR_W, then shifted left by 2:
  - B: imm26 = instruction[25:0].
  - CBZ/CBNZ and B.cond: imm19 = instruction[23:5].
- target = pc + (sext(imm) << 2), modulo 2^ADDR_W. Wrap-around both past max and below 0 is silent.
- Strobe priority when more than one is asserted: uncond_branch > zero_branch > flag_branch.
- Taken rules:
  - B: always taken.
  - CBZ: taken when reg_value==0.
  - CBNZ: taken when reg_value!=0.
  - B.cond: taken when the condition holds on the registered flags.
- Condition codes:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL and NV (1111) are always taken.
- Next pc is target when taken, otherwise pc+INST_BYTES (modulo).
- flags <= flags_in on an edge where flag_write=1, FSM=RUN and stall=0.
- Same-cycle flag_write and flag_branch: the branch evaluates the old flags, and the new flags are visible from the next cycle.
- branch_taken is 1 in the cycle after an edge on which a taken branch loaded pc, otherwise 0.
- There is no combinational path from inputs to any output.

Test Plan:
- Reset then 3 cycles of NOP (0xD503201F), no strobes -> pc 0,4,8,12; flags=0, halted=0, branch_taken=0.
- At pc=0x100, B with imm26=-2 (instruction 0x17FFFFFE), uncond_branch=1 -> pc=0xF8 next cycle, branch_taken=1 for exactly one cycle. With ADDR_W=16 and pc=0x0004, imm26=-4 -> pc=0xFFF4 (wrap).
- CBZ imm19=+4 at pc=0x40: reg_value=0 -> pc=0x50. Repeat with reg_value=5 -> pc=0x44. CBNZ (bit24=1) with reg_value=5 -> 0x50.
- flag_write=1, flags_in=4'b0100 (Z) -> flags=4'b0100 next cycle. Then B.EQ imm19=+2 at 0x200 -> 0x208. B.NE at 0x200 -> 0x204. Same-cycle flag_write of 4'b0000 with B.EQ still uses Z=1 and is taken. Cond 4'b1111 is taken.
- HLT (0xD4400000) at pc=0x30 -> halted=1 and pc stays 0x30 over 5 cycles, with strobes and flag_write ignored. resume=1 -> halted=0, pc=0x34. stall=1 for 3 cycles in RUN -> pc frozen, then it resumes incrementing.
- Reset asserted asynchronously mid-cycle while HALTED at pc=0x30 with flags=4'b1010 -> immediately pc=RESET_PC, flags=0, halted=0, before the next clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter, branch resolution, NZCV flags and HLT/resume
//               control for the ARMv8 core fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                 ADDR_W     = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int                 INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              stall,
  input  logic              uncond_branch,
  input  logic              zero_branch,
  input  logic              flag_branch,
  input  logic [63:0]       reg_value,
  input  logic              flag_write,
  input  logic [3:0]        flags_in,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              halted,
  output logic              branch_taken
);

  // Offsets are built at least 28 bits wide so narrow PCs still see a full
  // sign extension before truncation to ADDR_W.
  localparam int c_EXT_W = (ADDR_W > 28) ? ADDR_W : 28;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [3:0]          r_flags;
  logic [3:0]          w_flags_nxt;
  logic                r_branch_taken;
  logic                w_branch_taken_nxt;

  logic                w_hlt;
  logic [c_EXT_W-1:0]  w_off26;
  logic [c_EXT_W-1:0]  w_off19;
  logic [ADDR_W-1:0]   w_pc_seq;
  logic [ADDR_W-1:0]   w_target;
  logic                w_cond_base;
  logic                w_cond_ok;
  logic                w_taken;
  logic                w_n, w_z, w_c, w_v;

  assign w_hlt    = (instruction[31:21] == 11'b11010100010) &&
                    (instruction[4:0] == 5'b00000);
  assign w_off26  = {{(c_EXT_W-26){instruction[25]}}, instruction[25:0]} << 2;
  assign w_off19  = {{(c_EXT_W-19){instruction[23]}}, instruction[23:5]} << 2;
  assign w_pc_seq = r_pc + ADDR_W'(INST_BYTES);
  assign w_target = r_pc + (uncond_branch ? w_off26[ADDR_W-1:0]
                                          : w_off19[ADDR_W-1:0]);

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Odd condition codes invert their even partner, except NV which is taken.
  always_comb begin
    w_cond_base = 1'b1;
    case (instruction[3:1])
      3'b000:  w_cond_base = w_z;
      3'b001:  w_cond_base = w_c;
      3'b010:  w_cond_base = w_n;
      3'b011:  w_cond_base = w_v;
      3'b100:  w_cond_base = w_c & ~w_z;
      3'b101:  w_cond_base = (w_n == w_v);
      3'b110:  w_cond_base = ~w_z & (w_n == w_v);
      default: w_cond_base = 1'b1;
    endcase
  end

  assign w_cond_ok = (instruction[0] && (instruction[3:1] != 3'b111))
                     ? ~w_cond_base : w_cond_base;

  always_comb begin
    w_taken = 1'b0;
    if (uncond_branch) begin
      w_taken = 1'b1;
    end else if (zero_branch) begin
      w_taken = instruction[24] ? (reg_value != 64'd0) : (reg_value == 64'd0);
    end else if (flag_branch) begin
      w_taken = w_cond_ok;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_flags_nxt        = r_flags;
    w_branch_taken_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!stall) begin
          if (flag_write) begin
            w_flags_nxt = flags_in;
          end
          if (w_hlt) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_pc_nxt           = w_taken ? w_target : w_pc_seq;
            w_branch_taken_nxt = w_taken;
          end
        end
      end
      ST_HALTED: begin
        if (resume) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = w_pc_seq;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_PC;
      r_flags        <= 4'b0000;
      r_branch_taken <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_flags        <= w_flags_nxt;
      r_branch_taken <= w_branch_taken_nxt;
    end
  end

  assign pc           = r_pc;
  assign flags        = r_flags;
  assign halted       = (r_state == ST_HALTED);
  assign branch_taken = r_branch_taken;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] c_NOP = 32'hD503201F;
  localparam logic [31:0] c_HLT = 32'hD4400000;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        stall;
  logic        uncond_branch;
  logic        zero_branch;
  logic        flag_branch;
  logic [63:0] reg_value;
  logic        flag_write;
  logic [3:0]  flags_in;
  logic        resume;
  logic [63:0] pc;
  logic [3:0]  flags;
  logic        halted;
  logic        branch_taken;

  logic [31:0] instruction2;
  logic        stall2;
  logic        uncond2;
  logic [15:0] pc2;
  logic [3:0]  flags2;
  logic        halted2;
  logic        branch_taken2;

  int          n_checks;
  int          n_fail;
  logic [63:0] cur;

  pc_sequencer #(.ADDR_W(64), .RESET_PC(64'd0), .INST_BYTES(4)) u_dut (
    .clk(clk), .reset(reset), .instruction(instruction), .stall(stall),
    .uncond_branch(uncond_branch), .zero_branch(zero_branch),
    .flag_branch(flag_branch), .reg_value(reg_value), .flag_write(flag_write),
    .flags_in(flags_in), .resume(resume), .pc(pc), .flags(flags),
    .halted(halted), .branch_taken(branch_taken)
  );

  pc_sequencer #(.ADDR_W(16), .RESET_PC(16'h0004), .INST_BYTES(4)) u_dut16 (
    .clk(clk), .reset(reset), .instruction(instruction2), .stall(stall2),
    .uncond_branch(uncond2), .zero_branch(1'b0), .flag_branch(1'b0),
    .reg_value(64'd0), .flag_write(1'b0), .flags_in(4'b0000),
    .resume(1'b0), .pc(pc2), .flags(flags2), .halted(halted2),
    .branch_taken(branch_taken2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    instruction   = c_NOP;
    stall         = 1'b0;
    uncond_branch = 1'b0;
    zero_branch   = 1'b0;
    flag_branch   = 1'b0;
    reg_value     = 64'd0;
    flag_write    = 1'b0;
    flags_in      = 4'b0000;
    resume        = 1'b0;
  endtask

  task automatic tick(input string tag, input logic [63:0] ep, input logic eb);
    @(posedge clk);
    #1;
    chk({tag, "_pc"}, pc, ep);
    chk({tag, "_bt"}, 64'(branch_taken), 64'(eb));
    cur = ep;
    clear_inputs();
  endtask

  task automatic goto(input logic [63:0] addr);
    logic [63:0] d;
    d = addr - cur;
    instruction   = {6'b000101, d[27:2]};
    uncond_branch = 1'b1;
    tick("goto", addr, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur      = 64'd0;
    clear_inputs();
    reset        = 1'b1;
    instruction2 = 32'h17FFFFFC;
    stall2       = 1'b1;
    uncond2      = 1'b0;
    #12;
    chk("rst_pc", pc, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_bt", 64'(branch_taken), 64'd0);
    chk("rst_pc16", 64'(pc2), 64'h0004);
    reset   = 1'b0;
    stall2  = 1'b0;
    uncond2 = 1'b1;

    tick("nop0", 64'd4, 1'b0);
    stall2  = 1'b1;
    uncond2 = 1'b0;
    chk("wrap16_pc", 64'(pc2), 64'hFFF4);
    chk("wrap16_bt", 64'(branch_taken2), 64'd1);
    tick("nop1", 64'd8, 1'b0);
    tick("nop2", 64'd12, 1'b0);
    chk("nop_flags", 64'(flags), 64'd0);
    chk("nop_halted", 64'(halted), 64'd0);

    goto(64'h100);
    instruction = 32'h17FFFFFE; uncond_branch = 1'b1;
    tick("b_neg", 64'hF8, 1'b1);
    tick("b_after", 64'hFC, 1'b0);

    goto(64'h40);
    instruction = 32'hB4000080; zero_branch = 1'b1; reg_value = 64'd0;
    tick("cbz_taken", 64'h50, 1'b1);
    goto(64'h40);
    instruction = 32'hB4000080; zero_branch = 1'b1; reg_value = 64'd5;
    tick("cbz_not", 64'h44, 1'b0);
    goto(64'h40);
    instruction = 32'hB5000080; zero_branch = 1'b1; reg_value = 64'd5;
    tick("cbnz_taken", 64'h50, 1'b1);

    flag_write = 1'b1; flags_in = 4'b0100;
    tick("fw_z", 64'h54, 1'b0);
    chk("flags_z", 64'(flags), 64'b0100);

    goto(64'h200);
    instruction = 32'h54000040; flag_branch = 1'b1;
    tick("beq", 64'h208, 1'b1);
    goto(64'h200);
    instruction = 32'h54000041; flag_branch = 1'b1;
    tick("bne", 64'h204, 1'b0);
    goto(64'h200);
    instruction = 32'h54000040; flag_branch = 1'b1;
    flag_write = 1'b1; flags_in = 4'b0000;
    tick("beq_oldflags", 64'h208, 1'b1);
    chk("flags_cleared", 64'(flags), 64'd0);
    goto(64'h200);
    instruction = 32'h5400004F; flag_branch = 1'b1;
    tick("bnv", 64'h208, 1'b1);

    flag_write = 1'b1; flags_in = 4'b1010;
    tick("fw_nc", 64'h20C, 1'b0);
    chk("flags_nc", 64'(flags), 64'b1010);
    instruction = 32'h5400004B; flag_branch = 1'b1;
    tick("blt", 64'h214, 1'b1);
    instruction = 32'h5400004A; flag_branch = 1'b1;
    tick("bge", 64'h218, 1'b0);

    goto(64'h30);
    instruction = c_HLT; uncond_branch = 1'b1;
    tick("hlt", 64'h30, 1'b0);
    chk("hlt_halted", 64'(halted), 64'd1);
    for (int i = 0; i < 5; i++) begin
      instruction = 32'h14000010; uncond_branch = 1'b1;
      flag_write = 1'b1; flags_in = 4'b0000; stall = 1'b1;
      tick("halt_hold", 64'h30, 1'b0);
      chk("halt_halted", 64'(halted), 64'd1);
      chk("halt_flags", 64'(flags), 64'b1010);
    end
    instruction = c_HLT; resume = 1'b1;
    tick("resume", 64'h34, 1'b0);
    chk("resume_halted", 64'(halted), 64'd0);

    for (int i = 0; i < 3; i++) begin
      instruction = 32'h14000010; uncond_branch = 1'b1; stall = 1'b1;
      flag_write = 1'b1; flags_in = 4'b0001;
      tick("stall", 64'h34, 1'b0);
    end
    chk("stall_flags", 64'(flags), 64'b1010);
    tick("post_stall", 64'h38, 1'b0);

    goto(64'h30);
    instruction = c_HLT;
    tick("hlt2", 64'h30, 1'b0);
    chk("hlt2_halted", 64'(halted), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_pc", pc, 64'd0);
    chk("async_flags", 64'(flags), 64'd0);
    chk("async_halted", 64'(halted), 64'd0);
    chk("async_bt", 64'(branch_taken), 64'd0);
    #2;
    reset = 1'b0;
    cur   = 64'd0;
    tick("post_reset", 64'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
